q_path_exploit: RTL

- Downstream consumer of the Q-learning array. It takes the trained final_Q table, the blocked list, start_state and target_state, and walks the maze greedily.
- Each step picks the legal action with the highest Q value, commands next_state to the motion stage and starts the move timer. It then waits for move_complete and checks the reported maze_state.
- The walk ends with target_reached, or with a fault if the robot gets lost, gets stuck, or exceeds the step budget.

---
 rtl/q_path_exploit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/q_path_exploit.sv
// Greedy maze walker: follows the highest-Q legal action from start to target,
// commanding one move at a time to the motion stage and checking where it ended up.
module q_path_exploit #(
  parameter int N_STATES  = 37,
  parameter int GRID_W    = 6,
  parameter int N_ACT     = 4,
  parameter int QW        = 32,
  parameter int N_BLK     = 16,
  parameter int MAX_STEPS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [QW-1:0] final_Q [N_STATES][N_ACT],
  input  logic [5:0]           blocked [N_BLK],
  input  logic [5:0]           start_state,
  input  logic [5:0]           target_state,
  input  logic                 start,
  input  logic                 move_complete,
  input  logic [5:0]           maze_state,
  output logic [5:0]           next_state,
  output logic                 timer_start,
  output logic                 target_reached,
  output logic                 busy,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [6:0]           step_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT_MOVE, S_CHECK, S_DONE, S_FAULT
  } state_t;

  localparam logic [5:0]        GW     = 6'(GRID_W);
  localparam logic [5:0]        NCELL  = 6'(GRID_W * GRID_W);
  localparam logic [5:0]        NST    = 6'(N_STATES);
  localparam logic [6:0]        MAXS   = 7'(MAX_STEPS);
  localparam logic signed [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

  localparam logic [1:0] FC_NO_ACTION = 2'd1;
  localparam logic [1:0] FC_MISMATCH  = 2'd2;
  localparam logic [1:0] FC_BUDGET    = 2'd3;

  state_t                 state_q, state_d;
  logic [5:0]             cur_q, cur_d;
  logic [1:0]             act_q, act_d;
  logic [1:0]             best_act_q, best_act_d;
  logic signed [QW-1:0]   best_val_q, best_val_d;
  logic                   found_q, found_d;
  logic [5:0]             next_state_q, next_state_d;
  logic [6:0]             step_q, step_d;
  logic [1:0]             fcode_q, fcode_d;

  // Action order is fixed: up, down, left, right.
  function automatic logic [5:0] neighbour(input logic [5:0] s, input logic [1:0] a);
    case (a)
      2'd0:    return s - GW;
      2'd1:    return s + GW;
      2'd2:    return s - 6'd1;
      default: return s + 6'd1;
    endcase
  endfunction

  // Evaluation of the action currently indexed by act_q.
  logic                 cur_ok, edge_ok, hit_blk, cand_legal, cand_better, final_found;
  logic [5:0]           s_m1, row, col, cand_cell, q_row;
  logic [1:0]           final_act;
  logic signed [QW-1:0] cand_q;

  always_comb begin
    cur_ok    = (cur_q != 6'd0) && (cur_q <= NCELL);
    s_m1      = cur_q - 6'd1;
    row       = s_m1 / GW;
    col       = s_m1 % GW;
    cand_cell = neighbour(cur_q, act_q);
    case (act_q)
      2'd0:    edge_ok = (row != 6'd0);
      2'd1:    edge_ok = (row != GW - 6'd1);
      2'd2:    edge_ok = (col != 6'd0);
      default: edge_ok = (col != GW - 6'd1);
    endcase
    hit_blk = 1'b0;
    for (int i = 0; i < N_BLK; i++) begin
      if (blocked[i] != 6'd0 && blocked[i] == cand_cell) hit_blk = 1'b1;
    end
    cand_legal  = cur_ok && edge_ok && !hit_blk;
    q_row       = (cur_q < NST) ? cur_q : 6'd0;
    cand_q      = final_Q[q_row][act_q];
    // The found flag lets a legal action holding Q_MIN still win over "nothing".
    cand_better = cand_legal && (!found_q || (cand_q > best_val_q));
    final_act   = cand_better ? act_q : best_act_q;
    final_found = found_q | cand_better;
  end

  always_comb begin
    // NOTE: every next-state variable gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    cur_d        = cur_q;
    act_d        = act_q;
    best_act_d   = best_act_q;
    best_val_d   = best_val_q;
    found_d      = found_q;
    next_state_d = next_state_q;
    step_d       = step_q;
    fcode_d      = fcode_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          cur_d      = start_state;
          step_d     = 7'd0;
          fcode_d    = 2'd0;
          act_d      = 2'd0;
          found_d    = 1'b0;
          best_val_d = Q_MIN;
          state_d    = (start_state == target_state) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (cand_better) begin
          best_act_d = act_q;
          best_val_d = cand_q;
          found_d    = 1'b1;
        end
        act_d = act_q + 2'd1;
        if (act_q == 2'd3) begin
          if (!final_found) begin
            state_d = S_FAULT;
            fcode_d = FC_NO_ACTION;
          end else begin
            // Command is set up on entry so next_state is valid while timer_start is high.
            state_d      = S_ISSUE;
            next_state_d = neighbour(cur_q, final_act);
            step_d       = step_q + 7'd1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        if (move_complete) begin
          if (maze_state != next_state_q) begin
            state_d = S_FAULT;
            fcode_d = FC_MISMATCH;
          end else begin
            cur_d   = maze_state;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (cur_q == target_state) begin
          state_d = S_DONE;
        end else if (step_q == MAXS) begin
          state_d = S_FAULT;
          fcode_d = FC_BUDGET;
        end else begin
          state_d    = S_SELECT;
          act_d      = 2'd0;
          found_d    = 1'b0;
          best_val_d = Q_MIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= 6'd0;
      act_q        <= 2'd0;
      best_act_q   <= 2'd0;
      best_val_q   <= Q_MIN;
      found_q      <= 1'b0;
      next_state_q <= 6'd0;
      step_q       <= 7'd0;
      fcode_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      act_q        <= act_d;
      best_act_q   <= best_act_d;
      best_val_q   <= best_val_d;
      found_q      <= found_d;
      next_state_q <= next_state_d;
      step_q       <= step_d;
      fcode_q      <= fcode_d;
    end
  end

  assign next_state     = next_state_q;
  assign timer_start    = (state_q == S_ISSUE);
  assign target_reached = (state_q == S_DONE);
  assign fault          = (state_q == S_FAULT);
  assign busy           = !(state_q inside {S_IDLE, S_DONE, S_FAULT});
  assign fault_code     = fcode_q;
  assign step_count     = step_q;

endmodule
